ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter BUS_SIZE, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  reset is asynchronous and active-low.
REQ-004 i_start  input  1  operation request, sampled each rising edge.
REQ-005 i_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-006 i_flush  input  1  abort in-flight operation (pipeline flush).
REQ-007 i_data_a  input  BUS_SIZE  operand A (multiplicand/dividend/MTHI-MTLO source).
REQ-008 i_data_b  input  BUS_SIZE  operand B (multiplier/divisor).
REQ-009 o_busy  output  1  high while an operation is in flight; drives pipeline stall.
REQ-010 o_done  output  1  one-cycle pulse on completion.
REQ-011 o_div_by_zero  output  1  one-cycle pulse, coincident with o_done, for DIV/DIVU with i_data_b=0.
REQ-012 o_hi, o_lo  output  BUS_SIZE each  architectural HI/LO registers.

Function
REQ-013 FSM states IDLE, MUL, DIV, FIX, DONE; o_busy SHALL equal (state != IDLE).
REQ-014 Accept i_start only in IDLE; i_start while busy SHALL be ignored.
REQ-015 MTHI/MTLO in IDLE SHALL write i_data_a to HI/LO at that edge; no busy, no done.
REQ-016 MULT/MULTU/DIV/DIVU SHALL capture operand magnitudes and signs at the accept edge, then enter MUL or DIV with an iteration counter of BUS_SIZE.
REQ-017 MUL: one shift-add bit per cycle; DIV: one restoring subtract bit per cycle; BUS_SIZE iteration cycles, then FIX.
REQ-018 FIX SHALL apply signs and write HI/LO; DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-019 Fixed latency: o_done high in the cycle after the (BUS_SIZE+2)th rising edge following the accept edge; HI/LO hold new values in that same cycle.
REQ-020 Multiply: full 2*BUS_SIZE product, HI = upper half, LO = lower half; MULT signed, MULTU unsigned.
REQ-021 Divide: LO = quotient, HI = remainder; DIV quotient sign = sign(A) xor sign(B), remainder sign = sign(A); truncation toward zero.
REQ-022 DIV of most-negative value by -1 SHALL give LO = most-negative value, HI = 0.
REQ-023 DIV/DIVU with B = 0: FSM goes directly to DONE; o_done and o_div_by_zero pulse one cycle after accept; HI/LO unchanged.
REQ-024 i_flush SHALL return the FSM to IDLE at the next edge, suppress o_done, leave HI/LO unchanged; i_flush wins over a simultaneous i_start or MTHI/MTLO.

Reset
REQ-025 Reset assertion SHALL immediately force state IDLE, HI = 0, LO = 0, counter 0, o_busy/o_done/o_div_by_zero = 0, including mid-operation.
REQ-026 First accept possible at the first rising edge after reset deassertion.

Configuration
REQ-027 Macro EX_MULDIV_EARLY_OUT_EN defined: MUL SHALL jump to FIX in the cycle after the remaining multiplier bits become zero, giving variable latency of at least 3 cycles.
REQ-028 Macro not defined: MUL always runs all BUS_SIZE iterations (fixed latency per REQ-019); divide latency is unaffected in either case.

Structure
REQ-029 Shared package ex_muldiv_pkg SHALL hold the op encodings, FSM state encoding and default BUS_SIZE.
REQ-030 Sub-module muldiv_step (combinational, one multiply/divide iteration on partial result and operand) SHALL be instantiated once.

Verification (BUS_SIZE = 32, macro undefined unless stated)
REQ-031 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_done exactly per REQ-019; o_busy high throughout.
REQ-032 DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9 (-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 MTHI 0x11, MTLO 0x22, then DIV 5/0 -> o_done and o_div_by_zero one cycle after accept; HI=0x11, LO=0x22.
REQ-034 MULTU started, i_flush on 10th busy cycle, second i_start on 5th busy cycle -> busy low next edge, no o_done, HI/LO unchanged, second start ignored.
REQ-035 Reset asserted mid-DIV -> outputs and HI/LO zero immediately; new MULTU 6*7 after release -> LO=42, HI=0.
REQ-036 EX_MULDIV_EARLY_OUT_EN defined: MULTU 3*5 -> LO=15, HI=0, o_done well before BUS_SIZE+2 edges.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ex_muldiv_pkg;

  localparam int BUS_SIZE_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply bit or restoring-divide bit.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: is_div selects divide; part = partial product / remainder, opnd = multiplicand / divisor,
//        shreg = multiplier (consumed LSB first) / dividend (consumed MSB first, quotient shifted in).
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] part,
  input  logic [W-1:0] opnd,
  input  logic [W-1:0] shreg,
  output logic [W-1:0] part_nxt,
  output logic [W-1:0] shreg_nxt
);

  logic [W:0]   sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    sum    = {1'b0, part} + (shreg[0] ? {1'b0, opnd} : '0);
    rem_sh = {part, shreg[W-1]};
    ge     = (rem_sh >= {1'b0, opnd});
    // When ge holds the true difference is below opnd, so the low W bits are exact.
    diff   = rem_sh[W-1:0] - opnd;
    if (is_div) begin
      part_nxt  = ge ? diff : rem_sh[W-1:0];
      shreg_nxt = {shreg[W-2:0], ge};
    end else begin
      // Product low bits leave the adder LSB and enter shreg from the top.
      part_nxt  = sum[W:1];
      shreg_nxt = {sum[0], shreg[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit with MTHI/MTLO writes.
// Latency: MUL/DIV BUS_SIZE+2 busy cycles; divide by zero 1 cycle; MTHI/MTLO write at the accept edge.
// Backpressure: o_busy stalls the pipeline; i_start while busy is ignored; i_flush aborts.
// Ports: i_clk, i_reset (async active-low), i_start/i_op/i_data_a/i_data_b request,
//        i_flush abort, o_busy, o_done, o_div_by_zero pulses, o_hi/o_lo architectural registers.
// Build option: EX_MULDIV_EARLY_OUT_EN ends MUL as soon as the remaining multiplier bits are zero.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [2:0]          i_op,
  input  logic                i_flush,
  input  logic [BUS_SIZE-1:0] i_data_a,
  input  logic [BUS_SIZE-1:0] i_data_b,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_div_by_zero,
  output logic [BUS_SIZE-1:0] o_hi,
  output logic [BUS_SIZE-1:0] o_lo
);

  localparam int CW = $clog2(BUS_SIZE + 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [BUS_SIZE-1:0]   part, opnd, shreg, hi, lo;
  logic [BUS_SIZE-1:0]   part_nxt, shreg_nxt, a_mag, b_mag, hi_res, lo_res;
  logic [2*BUS_SIZE-1:0] prod, prod_s;
  logic                  is_div, neg_lo, neg_hi, dbz;
  logic                  is_mul_op, is_div_op, sign_a, sign_b, b_zero;
  logic                  accept, mt_wr, mul_hold, step_en;

  always_comb begin
    is_mul_op = (i_op == OP_MULT) || (i_op == OP_MULTU);
    is_div_op = (i_op == OP_DIV) || (i_op == OP_DIVU);
    sign_a    = ((i_op == OP_MULT) || (i_op == OP_DIV)) && i_data_a[BUS_SIZE-1];
    sign_b    = ((i_op == OP_MULT) || (i_op == OP_DIV)) && i_data_b[BUS_SIZE-1];
    a_mag     = sign_a ? -i_data_a : i_data_a;
    b_mag     = sign_b ? -i_data_b : i_data_b;
    b_zero    = (i_data_b == '0);
    accept    = (state == IDLE) && i_start && !i_flush && (is_mul_op || is_div_op);
    mt_wr     = (state == IDLE) && i_start && !i_flush && ((i_op == OP_MTHI) || (i_op == OP_MTLO));
  end

`ifdef EX_MULDIV_EARLY_OUT_EN
  // Unconsumed multiplier bits sit in shreg[cnt-1:0]; once they are all zero the remaining
  // iterations would only shift, so that shift is applied in FIX instead.
  logic [BUS_SIZE-1:0] rem_mask;
  assign rem_mask = {BUS_SIZE{1'b1}} >> (BUS_SIZE - int'(cnt));
  assign mul_hold = ((shreg & rem_mask) == '0);
  assign prod     = {part, shreg} >> cnt;
`else
  assign mul_hold = 1'b0;
  assign prod     = {part, shreg};
`endif

  assign step_en = ((state == MUL) && !mul_hold) || (state == DIV);

  muldiv_step #(.W(BUS_SIZE)) u_step (
    .is_div    (is_div),
    .part      (part),
    .opnd      (opnd),
    .shreg     (shreg),
    .part_nxt  (part_nxt),
    .shreg_nxt (shreg_nxt)
  );

  // Sign fix-up: quotient/product sign in neg_lo, remainder follows the dividend (neg_hi).
  always_comb begin
    prod_s = neg_lo ? -prod : prod;
    if (is_div) begin
      lo_res = neg_lo ? -shreg : shreg;
      hi_res = neg_hi ? -part : part;
    end else begin
      lo_res = prod_s[BUS_SIZE-1:0];
      hi_res = prod_s[2*BUS_SIZE-1:BUS_SIZE];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul_op ? MUL : (b_zero ? DONE : DIV);
      MUL: begin
        if (i_flush)                          state_nxt = IDLE;
        else if (mul_hold || cnt == CW'(1))   state_nxt = FIX;
      end
      DIV: begin
        if (i_flush)                          state_nxt = IDLE;
        else if (cnt == CW'(1))               state_nxt = FIX;
      end
      FIX:     state_nxt = i_flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt    <= '0;
      part   <= '0;
      opnd   <= '0;
      shreg  <= '0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      if (accept) begin
        is_div <= is_div_op;
        neg_lo <= sign_a ^ sign_b;
        neg_hi <= sign_a;
        dbz    <= is_div_op && b_zero;
        part   <= '0;
        opnd   <= is_div_op ? b_mag : a_mag;
        shreg  <= is_div_op ? a_mag : b_mag;
        cnt    <= CW'(BUS_SIZE);
      end else if (step_en && !i_flush) begin
        part  <= part_nxt;
        shreg <= shreg_nxt;
        cnt   <= cnt - CW'(1);
      end
      if ((state == FIX) && !i_flush) begin
        hi <= hi_res;
        lo <= lo_res;
      end
      if (mt_wr) begin
        if (i_op == OP_MTHI) hi <= i_data_a;
        else                 lo <= i_data_a;
      end
    end
  end

  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);
  assign o_div_by_zero = (state == DONE) && dbz;
  assign o_hi          = hi;
  assign o_lo          = lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed HI/LO results, latency, flush and reset behaviour.
// Latency below is counted as rising edges including the accept edge (accept edge = 1).
// Backpressure exercised through i_start while busy and i_flush.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b111;
  logic [N-1:0] da = '0;
  logic [N-1:0] db = '0;
  logic         busy, done, dbz;
  logic [N-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.BUS_SIZE(N)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_flush       (flush),
    .i_data_a      (da),
    .i_data_b      (db),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for o_done.
  task automatic do_op(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat, output logic dz, output logic busy_ok);
    op = o; da = a; db = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    busy_ok = busy_ok & busy;
    dz = dbz;
  endtask

  task automatic mul_case(input string tag, input logic [2:0] o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo);
    int lat; logic dz, bok;
    do_op(o, a, b, lat, dz, bok);
`ifdef EX_MULDIV_EARLY_OUT_EN
    check({tag, "_lat_max"}, 64'(lat <= LAT), 1);
`else
    check({tag, "_lat"}, lat, LAT);
`endif
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy"}, bok, 1);
    check({tag, "_dbz"}, dz, 0);
    tick();
    check({tag, "_after"}, {busy, done}, 2'b00);
  endtask

  task automatic div_case(input string tag, input logic [2:0] o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo);
    int lat; logic dz, bok;
    do_op(o, a, b, lat, dz, bok);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy"}, bok, 1);
    check({tag, "_dbz"}, dz, 0);
    tick();
    check({tag, "_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat; int ndone; logic dz, bok;

    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz",  dbz, 0);
    check("rst_hi",   hi, 0);
    check("rst_lo",   lo, 0);
    rst_n = 1'b1;

    mul_case("mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    mul_case("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    mul_case("mult_minmin", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    mul_case("mult_negneg", OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);

    div_case("divu_100_7",  OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    div_case("divu_big",    OP_DIVU, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999);
    div_case("div_neg_a",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    div_case("div_neg_b",   OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    div_case("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);

    // MTHI / MTLO write at the accept edge without busy or done.
    op = OP_MTHI; da = 32'h11; start = 1'b1;
    tick();
    start = 1'b0;
    check("mthi_hi", hi, 32'h11);
    check("mthi_flags", {busy, done}, 2'b00);
    op = OP_MTLO; da = 32'h22; start = 1'b1;
    tick();
    start = 1'b0;
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi", hi, 32'h11);

    // Divide by zero: done and flag one cycle after accept, HI/LO untouched.
    do_op(OP_DIV, 32'd5, 32'd0, lat, dz, bok);
    check("dbz_lat", lat, 1);
    check("dbz_flag", dz, 1);
    check("dbz_hi", hi, 32'h11);
    check("dbz_lo", lo, 32'h22);
    tick();
    check("dbz_after", {busy, done, dbz}, 3'b000);

    // Flush on the 10th busy cycle; a second start on the 5th must be ignored.
    ndone = 0;
    op = OP_MULTU; da = 32'd9; db = 32'h80000009; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) ndone++;
      if (c == 5) begin op = OP_DIVU; db = '0; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      tick();
    end
    check("flush_no_done", ndone, 0);
    check("flush_hi_late", hi, 32'h11);
    check("flush_lo_late", lo, 32'h22);

    // Flush beats a simultaneous MTLO.
    op = OP_MTLO; da = 32'h77; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_mtlo", lo, 32'h22);

    // Asynchronous reset in the middle of a divide.
    op = OP_DIV; da = 32'd1000; db = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("mid_div_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_flags", {busy, done, dbz}, 3'b000);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    tick();
    rst_n = 1'b1;
    mul_case("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

`ifdef EX_MULDIV_EARLY_OUT_EN
    do_op(OP_MULTU, 32'd3, 32'd5, lat, dz, bok);
    check("early_lo", lo, 32'd15);
    check("early_hi", hi, 32'd0);
    check("early_lat", 64'(lat <= 8), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
